mac_array_ws: RTL and testbench

Parametrised weight-stationary systolic MAC array, the successor to the fixed 4x4 array. It computes y = W·a for one COLS-element input vector per cycle against a ROWS x COLS weight matrix. Input skew and output deskew are internal, so callers present and receive aligned vectors. The block adds valid/ready flow control, double-buffered weights with a safe commit, and saturating outputs. It sits between the activation streamer and the result writer in the accelerator datapath.

---
 rtl/mac_array_ws.sv | 213 +++++++++++++++++++++
 tb/tb_mac_array_ws.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_ws.sv
// Weight-stationary systolic MAC array computing y = W*a with internal input skew and output
// deskew, valid/ready flow control, double-buffered weights and saturating outputs.
module mac_array_ws #(
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4,
    parameter int unsigned DW     = 8,
    parameter bit          SIGNED = 1'b1,
    parameter int unsigned AW     = 2 * DW + $clog2(COLS) + 1,
    parameter int unsigned OW     = 16,
    parameter int unsigned RWB    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 CLR,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [COLS*DW-1:0]   IN_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [ROWS*OW-1:0]   OUT_DATA,
    output logic [ROWS-1:0]      OUT_SAT,
    input  logic                 W_LOAD,
    input  logic [RWB-1:0]       W_ROW,
    input  logic [COLS*DW-1:0]   W_DATA,
    input  logic                 W_COMMIT,
    output logic                 W_BUSY
);
    localparam int unsigned LAT = ROWS + COLS;
    localparam int unsigned CW  = $clog2(LAT + 2);

    localparam logic [AW-1:0] SMax = AW'({(OW - 1){1'b1}});
    localparam logic [AW-1:0] SMin = ~SMax;
    localparam logic [AW-1:0] UMax = AW'({OW{1'b1}});

    typedef enum logic [1:0] {StRun, StDrain, StSwap} state_e;

    state_e                            state_q, state_d;
    logic                              adv, in_hs, out_hs;
    logic [LAT-1:0]                    vld_q, vld_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic [ROWS-1:0][COLS-1:0][DW-1:0] w_act_q, w_act_d, w_sh_q, w_sh_d;
    logic [ROWS*OW-1:0]                out_data_q, out_data_d;
    logic [ROWS-1:0]                   out_sat_q, out_sat_d;
    logic [ROWS-1:0][COLS-1:0][DW-1:0] a_bus;    // activation entering PE(i,j)
    logic [ROWS-1:0][COLS:0][AW-1:0]   p_bus;    // partial sum entering PE(i,j)
    logic [ROWS-1:0][AW-1:0]           row_sum;  // deskewed row result

    function automatic logic [AW-1:0] ext(input logic [DW-1:0] v);
        if (SIGNED) return AW'($signed(v));
        return AW'(v);
    endfunction

    assign adv       = !(vld_q[LAT-1] && !OUT_READY);
    assign IN_READY  = adv && (state_q == StRun);
    assign in_hs     = IN_VALID && IN_READY;
    assign out_hs    = vld_q[LAT-1] && OUT_READY;
    assign OUT_VALID = vld_q[LAT-1];
    assign OUT_DATA  = out_data_q;
    assign OUT_SAT   = out_sat_q;
    assign W_BUSY    = (state_q != StRun);

    always_comb begin
        vld_d = vld_q;
        if (CLR) vld_d = '0;
        else if (adv) vld_d = {vld_q[LAT-2:0], in_hs};
    end

    always_comb begin
        cnt_d = cnt_q;
        if (CLR) cnt_d = '0;
        else if (in_hs && !out_hs) cnt_d = cnt_q + CW'(1);
        else if (!in_hs && out_hs) cnt_d = cnt_q - CW'(1);
    end

    // A load in the same cycle as a commit lands in the shadow before the swap reads it.
    always_comb begin
        state_d = state_q;
        w_sh_d  = w_sh_q;
        w_act_d = w_act_q;
        unique case (state_q)
            StRun: begin
                if (W_LOAD && (32'(W_ROW) < ROWS)) begin
                    for (int j = 0; j < COLS; j++) begin
                        w_sh_d[W_ROW][j] = W_DATA[(COLS-j)*DW-1 -: DW];
                    end
                end
                if (W_COMMIT) state_d = StDrain;
            end
            StDrain: if (cnt_q == '0) state_d = StSwap;
            StSwap: begin
                w_act_d = w_sh_q;
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        if (adv) begin
            for (int i = 0; i < ROWS; i++) begin
                out_sat_d[i] = 1'b0;
                out_data_d[(ROWS-i)*OW-1 -: OW] = row_sum[i][OW-1:0];
                if (SIGNED) begin
                    if ($signed(row_sum[i]) > $signed(SMax)) begin
                        out_sat_d[i] = 1'b1;
                        out_data_d[(ROWS-i)*OW-1 -: OW] = SMax[OW-1:0];
                    end else if ($signed(row_sum[i]) < $signed(SMin)) begin
                        out_sat_d[i] = 1'b1;
                        out_data_d[(ROWS-i)*OW-1 -: OW] = SMin[OW-1:0];
                    end
                end else if (row_sum[i] > UMax) begin
                    out_sat_d[i] = 1'b1;
                    out_data_d[(ROWS-i)*OW-1 -: OW] = UMax[OW-1:0];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= StRun;
            vld_q      <= '0;
            cnt_q      <= '0;
            w_act_q    <= '0;
            w_sh_q     <= '0;
            out_data_q <= '0;
            out_sat_q  <= '0;
        end else begin
            state_q    <= state_d;
            vld_q      <= vld_d;
            cnt_q      <= cnt_d;
            w_act_q    <= w_act_d;
            w_sh_q     <= w_sh_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    // Idle cycles inject zeros so bubbles carry clean zero sums.
    for (genvar j = 0; j < COLS; j++) begin : g_skew
        logic [DW-1:0] a_in;
        assign a_in = in_hs ? IN_DATA[(COLS-j)*DW-1 -: DW] : '0;
        if (j == 0) begin : g_direct
            assign a_bus[0][j] = a_in;
        end else begin : g_delay
            logic [j-1:0][DW-1:0] sk_q, sk_d;
            always_comb begin
                sk_d = sk_q;
                if (adv) begin
                    sk_d[0] = a_in;
                    for (int k = 1; k < j; k++) sk_d[k] = sk_q[k-1];
                end
            end
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) sk_q <= '0;
                else       sk_q <= sk_d;
            end
            assign a_bus[0][j] = sk_q[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        localparam int unsigned Dly = ROWS - 1 - i;
        assign p_bus[i][0] = '0;

        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic [AW-1:0] p_q, p_d;
            always_comb begin
                p_d = p_q;
                if (adv) p_d = p_bus[i][j] + ext(a_bus[i][j]) * ext(w_act_q[i][j]);
            end
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) p_q <= '0;
                else       p_q <= p_d;
            end
            assign p_bus[i][j+1] = p_q;

            if (i < ROWS - 1) begin : g_fwd
                logic [DW-1:0] a_q, a_d;
                always_comb begin
                    a_d = a_q;
                    if (adv) a_d = a_bus[i][j];
                end
                always_ff @(posedge CLK or negedge RSTN) begin
                    if (!RSTN) a_q <= '0;
                    else       a_q <= a_d;
                end
                assign a_bus[i+1][j] = a_q;
            end
        end

        if (Dly == 0) begin : g_nodesk
            assign row_sum[i] = p_bus[i][COLS];
        end else begin : g_desk
            logic [Dly-1:0][AW-1:0] ds_q, ds_d;
            always_comb begin
                ds_d = ds_q;
                if (adv) begin
                    ds_d[0] = p_bus[i][COLS];
                    for (int k = 1; k < Dly; k++) ds_d[k] = ds_q[k-1];
                end
            end
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) ds_q <= '0;
                else       ds_q <= ds_d;
            end
            assign row_sum[i] = ds_q[Dly-1];
        end
    end

endmodule

// File: tb/tb_mac_array_ws.sv
// Directed bench for mac_array_ws: a scoreboard of expected result vectors is filled on each
// input handshake and drained by a monitor on each output handshake.
module tb_mac_array_ws;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int OW   = 16;
    localparam int AW   = 2 * DW + $clog2(COLS) + 1;
    localparam int RWB  = 2;
    localparam int LAT  = ROWS + COLS;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clr = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [COLS*DW-1:0]   in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [ROWS*OW-1:0]   out_data;
    logic [ROWS-1:0]      out_sat;
    logic                 w_load = 1'b0;
    logic [RWB-1:0]       w_row = '0;
    logic [COLS*DW-1:0]   w_data = '0;
    logic                 w_commit = 1'b0;
    logic                 w_busy;

    mac_array_ws #(
        .ROWS(ROWS), .COLS(COLS), .DW(DW), .SIGNED(1'b1), .AW(AW), .OW(OW), .RWB(RWB)
    ) dut (
        .CLK(clk), .RSTN(rst_n), .CLR(clr),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data), .OUT_SAT(out_sat),
        .W_LOAD(w_load), .W_ROW(w_row), .W_DATA(w_data), .W_COMMIT(w_commit), .W_BUSY(w_busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int run_len = 0;
    int max_run = 0;
    int busy;
    int cyc;

    logic signed [DW-1:0] w_sh  [ROWS][COLS];
    logic signed [DW-1:0] w_act [ROWS][COLS];
    logic [ROWS*OW-1:0]   exp_data_q [$];
    logic [ROWS-1:0]      exp_sat_q  [$];
    logic [ROWS*OW-1:0]   mon_d;
    logic [ROWS-1:0]      mon_s;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    function automatic logic [COLS*DW-1:0] vec(input int a0, input int a1, input int a2,
                                               input int a3);
        return {8'(a0), 8'(a1), 8'(a2), 8'(a3)};
    endfunction

    function automatic void calc(input logic [COLS*DW-1:0] v, output logic [ROWS*OW-1:0] d,
                                 output logic [ROWS-1:0] s);
        longint acc;
        longint vmax;
        longint vmin;
        logic signed [DW-1:0] a;
        vmax = (longint'(1) << (OW - 1)) - 1;
        vmin = -(longint'(1) << (OW - 1));
        d = '0;
        s = '0;
        for (int i = 0; i < ROWS; i++) begin
            acc = 0;
            for (int j = 0; j < COLS; j++) begin
                a = v[(COLS-j)*DW-1 -: DW];
                acc += longint'(a) * longint'(w_act[i][j]);
            end
            if (acc > vmax) begin
                acc = vmax;
                s[i] = 1'b1;
            end else if (acc < vmin) begin
                acc = vmin;
                s[i] = 1'b1;
            end
            d[(ROWS-i)*OW-1 -: OW] = acc[OW-1:0];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_row(input int r, input logic [COLS*DW-1:0] v);
        w_load = 1'b1;
        w_row  = RWB'(r);
        w_data = v;
        for (int j = 0; j < COLS; j++) w_sh[r][j] = v[(COLS-j)*DW-1 -: DW];
        tick();
        w_load = 1'b0;
    endtask

    task automatic commit(output int nbusy);
        w_commit = 1'b1;
        tick();
        w_commit = 1'b0;
        nbusy = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!w_busy) break;
            nbusy++;
            check("in_ready_low_while_busy", in_ready, 0);
            tick();
        end
        tick();
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) w_act[i][j] = w_sh[i][j];
    endtask

    task automatic send(input logic [COLS*DW-1:0] v);
        logic [ROWS*OW-1:0] d;
        logic [ROWS-1:0]    s;
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("send_accepted", ok, 1);
        if (ok) begin
            calc(v, d, s);
            exp_data_q.push_back(d);
            exp_sat_q.push_back(s);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_data_q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check("drain_complete", done, 1);
        tick();
    endtask

    task automatic reset_model();
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                w_sh[i][j]  = '0;
                w_act[i][j] = '0;
            end
        exp_data_q.delete();
        exp_sat_q.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (out_valid && out_ready) begin
                check("output_expected", exp_data_q.size() != 0, 1);
                if (exp_data_q.size() != 0) begin
                    mon_d = exp_data_q.pop_front();
                    mon_s = exp_sat_q.pop_front();
                    check("out_data", out_data, mon_d);
                    check("out_sat", out_sat, mon_s);
                end
            end
        end
    end

    initial begin
        reset_model();
        #12 rst_n = 1'b1;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_w_busy", w_busy, 0);
        check("rst_in_ready", in_ready, 1);

        // Identity weights, empty-pipeline commit, latency.
        for (int r = 0; r < ROWS; r++)
            load_row(r, vec(r == 0 ? 1 : 0, r == 1 ? 1 : 0, r == 2 ? 1 : 0, r == 3 ? 1 : 0));
        commit(busy);
        check("commit_empty_busy", busy, 2);
        send(vec(1, 2, 3, 4));
        cyc = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid) break;
            tick();
            cyc++;
        end
        check("latency", cyc, LAT);
        check("identity_data", out_data, 64'h0001_0002_0003_0004);
        tick();
        wait_drain();

        // Streaming with W[i][j] = i+1.
        for (int r = 0; r < ROWS; r++) load_row(r, vec(r + 1, r + 1, r + 1, r + 1));
        commit(busy);
        check("commit_empty_busy2", busy, 2);
        max_run = 0;
        for (int n = 0; n < 16; n++)
            send(vec($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 255)));
        wait_drain();
        check("stream_run_len", max_run, 16);

        // Backpressure: stall the output for 5 cycles mid-stream.
        for (int n = 0; n < 10; n++) send(vec(n, -n, 2 * n, 3));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = vec(10, -10, 20, 3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_data", out_data, exp_data_q[0]);
            tick();
        end
        out_ready = 1'b1;
        for (int n = 10; n < 16; n++) send(vec(n, -n, 2 * n, 3));
        wait_drain();

        // Commit with three vectors in flight: old weights apply to them, new ones afterwards.
        for (int r = 0; r < ROWS; r++) load_row(r, vec(-r, 1 - r, 2 - r, 3 - r));
        send(vec(1, 1, 1, 1));
        send(vec(2, 3, 4, 5));
        send(vec(-7, 6, -5, 4));
        commit(busy);
        check("commit_traffic_busy", busy, 9);
        check("commit_traffic_drained", exp_data_q.size(), 0);
        send(vec(1, 1, 1, 1));
        send(vec(9, -8, 7, -6));
        wait_drain();

        // Saturation at both ends of the signed range.
        for (int r = 0; r < ROWS; r++) load_row(r, vec(127, 127, 127, 127));
        commit(busy);
        send(vec(127, 127, 127, 127));
        send(vec(-128, -128, -128, -128));
        wait_drain();

        // CLR mid-stream flushes in-flight vectors.
        for (int n = 0; n < 4; n++) send(vec(n + 1, 2, 3, 4));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_data_q.delete();
        exp_sat_q.delete();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("clr_no_output", out_valid, 0);
            tick();
        end

        // Asynchronous reset mid-stream, then zero weights give zero results.
        for (int n = 0; n < 4; n++) send(vec(3, n, 1, 1));
        #2 rst_n = 1'b0;
        reset_model();
        tick();
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("rst_no_output", out_valid, 0);
            tick();
        end
        check("rst2_w_busy", w_busy, 0);
        check("rst2_in_ready", in_ready, 1);
        send(vec(5, 5, 5, 5));
        wait_drain();
        check("scoreboard_empty", exp_data_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
